// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Each op takes three cycles: accept in IDLE, drive the ALU in EXEC, return the result in RESP.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] res_reg;
  logic             owner;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             owner_ready;

  // Contention goes to the port that lost last time; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign owner_ready = owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = EXEC;
        EXEC:    state_next = RESP;
        RESP:    if (owner_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Readies are withheld during a flush so an aborted cycle never records a request.
  always_comb begin
    req0_ready  = (state == IDLE) && !flush && !grant;
    req1_ready  = (state == IDLE) && !flush && grant;
    resp0_valid = (state == RESP) && !owner;
    resp1_valid = (state == RESP) && owner;
    busy        = (state != IDLE);
  end

  // last_grant moves only on an accepted request, never on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= 4'b0000;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_a       <= grant ? req1_a : req0_a;
      op_b       <= grant ? req1_b : req0_b;
      op_sel     <= grant ? req1_sel : req0_sel;
      owner      <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg <= '0;
    end else if ((state == EXEC) && !flush) begin
      res_reg <= alu_result;
    end
  end

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_sel     = op_sel;
  assign resp_result = res_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small behavioural ALU attached to its ALU port.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        busy;

  typedef struct {
    logic        port;
    logic [31:0] result;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU; unknown select codes return 0.
  always_comb begin
    alu_result = 32'h0;
    case (alu_sel)
      4'b0000: alu_result = alu_a + alu_b;
      4'b1000: alu_result = alu_a - alu_b;
      4'b0010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'h1 : 32'h0;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic port, input logic [31:0] result);
    exp_t e;
    e.port   = port;
    e.result = result;
    sbq.push_back(e);
  endtask

  task automatic scoreCheck(input logic port);
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected_resp: got response on port %0d result 0x%0h, expected none", port, resp_result);
    end else begin
      e = sbq.pop_front();
      checkOutput("resp_port", {31'b0, port}, {31'b0, e.port});
      checkOutput("resp_result", resp_result, e.result);
    end
  endtask

  // Monitor: every response handshake is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp0_valid && resp0_ready) scoreCheck(1'b0);
      if (resp1_valid && resp1_ready) scoreCheck(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1);
    step();
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    #2;
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_resp0_valid", {31'b0, resp0_valid}, 32'h0);
    checkOutput("rst_resp1_valid", {31'b0, resp1_valid}, 32'h0);
    checkOutput("rst_alu_a", alu_a, 32'h0);
    checkOutput("rst_alu_b", alu_b, 32'h0);
    checkOutput("rst_alu_sel", {28'b0, alu_sel}, 32'h0);
    checkOutput("rst_resp_result", resp_result, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Single op on port 0: 5 + 3
    applyStimulus(1'b1, 32'd5, 32'd3, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(negedge clk);
    checkOutput("t1_req0_ready", {31'b0, req0_ready}, 32'h1);
    checkOutput("t1_req1_ready", {31'b0, req1_ready}, 32'h0);
    pushExp(1'b0, 32'd8);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(negedge clk);
    checkOutput("t1_exec_busy", {31'b0, busy}, 32'h1);
    checkOutput("t1_exec_alu_a", alu_a, 32'd5);
    checkOutput("t1_exec_alu_b", alu_b, 32'd3);
    checkOutput("t1_exec_resp0_valid", {31'b0, resp0_valid}, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t1_resp0_valid", {31'b0, resp0_valid}, 32'h1);
    checkOutput("t1_resp1_valid", {31'b0, resp1_valid}, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t1_idle", {31'b0, busy}, 32'h0);

    // Contention from reset: grants alternate 0,1,0,1 every third cycle
    step();
    doReset();
    applyStimulus(1'b1, 32'd10, 32'd4, 4'b1000, 1'b1, 32'hF0, 32'h0F, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(negedge clk);
      else repeat (3) @(negedge clk);
      checkOutput($sformatf("t2_grant%0d_req0_ready", i), {31'b0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t2_grant%0d_req1_ready", i), {31'b0, req1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t2_grant%0d_idle", i), {31'b0, busy}, 32'h0);
      pushExp(i % 2 == 1, (i % 2 == 1) ? 32'hFF : 32'd6);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checkOutput("t2_idle", {31'b0, busy}, 32'h0);

    // Backpressure on port 1 while port 0 waits
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd7, 32'd2, 4'b0000);
    resp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3_req1_ready", {31'b0, req1_ready}, 32'h1);
    checkOutput("t3_req0_ready", {31'b0, req0_ready}, 32'h0);
    pushExp(1'b1, 32'd9);
    applyStimulus(1'b1, 32'd1, 32'd1, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_stall%0d_resp1_valid", j), {31'b0, resp1_valid}, 32'h1);
      checkOutput($sformatf("t3_stall%0d_result", j), resp_result, 32'd9);
      checkOutput($sformatf("t3_stall%0d_busy", j), {31'b0, busy}, 32'h1);
      checkOutput($sformatf("t3_stall%0d_req0_ready", j), {31'b0, req0_ready}, 32'h0);
      step();
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_release_req0_ready", {31'b0, req0_ready}, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t3_idle", {31'b0, busy}, 32'h0);
    checkOutput("t3_req0_ready", {31'b0, req0_ready}, 32'h1);
    pushExp(1'b0, 32'd2);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checkOutput("t3_drained", {31'b0, busy}, 32'h0);

    // Flush during EXEC discards the op and leaves last_grant at 0
    applyStimulus(1'b1, 32'd100, 32'd1, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(negedge clk);
    checkOutput("t4_req0_ready", {31'b0, req0_ready}, 32'h1);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("t4_exec_busy", {31'b0, busy}, 32'h1);
    checkOutput("t4_exec_resp0_valid", {31'b0, resp0_valid}, 32'h0);
    step();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_flush_idle", {31'b0, busy}, 32'h0);
    checkOutput("t4_flush_resp0_valid", {31'b0, resp0_valid}, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t4_flush_resp0_valid2", {31'b0, resp0_valid}, 32'h0);
    applyStimulus(1'b1, 32'd9, 32'd9, 4'b0000, 1'b1, 32'd3, 32'd5, 4'b1000);
    @(negedge clk);
    checkOutput("t4_rr_req1_ready", {31'b0, req1_ready}, 32'h1);
    checkOutput("t4_rr_req0_ready", {31'b0, req0_ready}, 32'h0);
    pushExp(1'b1, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checkOutput("t4_rr_idle", {31'b0, busy}, 32'h0);

    // Flush in IDLE blocks acceptance for that cycle only
    applyStimulus(1'b1, 32'd2, 32'd2, 4'b0111, 1'b0, 32'd0, 32'd0, 4'b0000);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("t4_idleflush_req0_ready", {31'b0, req0_ready}, 32'h0);
    checkOutput("t4_idleflush_req1_ready", {31'b0, req1_ready}, 32'h0);
    step();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_idleflush_not_taken", {31'b0, busy}, 32'h0);
    checkOutput("t4_idleflush_req0_ready_after", {31'b0, req0_ready}, 32'h1);
    pushExp(1'b0, 32'd2);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checkOutput("t4_idleflush_drained", {31'b0, busy}, 32'h0);

    // Asynchronous reset while a port 1 response is stalled
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd1, 32'd1, 4'b0000);
    resp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("t5_req1_ready", {31'b0, req1_ready}, 32'h1);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    @(negedge clk);
    checkOutput("t5_resp1_valid", {31'b0, resp1_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_resp1_valid", {31'b0, resp1_valid}, 32'h0);
    checkOutput("t5_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("t5_rst_resp_result", resp_result, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    resp1_ready = 1'b1;
    applyStimulus(1'b1, 32'd4, 32'd4, 4'b0000, 1'b1, 32'd6, 32'd6, 4'b0000);
    @(negedge clk);
    checkOutput("t5_first_req0_ready", {31'b0, req0_ready}, 32'h1);
    checkOutput("t5_first_req1_ready", {31'b0, req1_ready}, 32'h0);
    pushExp(1'b0, 32'd8);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    step();
    step();
    @(negedge clk);
    checkOutput("t5_drained", {31'b0, busy}, 32'h0);

    // Signed compare: ALU sees only latched operands, not live request inputs
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(negedge clk);
    checkOutput("t6_req0_ready", {31'b0, req0_ready}, 32'h1);
    pushExp(1'b0, 32'd1);
    applyStimulus(1'b0, 32'h1234_5678, 32'd9, 4'b1111, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(negedge clk);
    checkOutput("t6_exec_alu_sel", {28'b0, alu_sel}, 32'h2);
    checkOutput("t6_exec_alu_a", alu_a, 32'hFFFF_FFFF);
    checkOutput("t6_exec_alu_b", alu_b, 32'd1);
    step();
    step();
    @(negedge clk);
    checkOutput("t6_idle", {31'b0, busy}, 32'h0);
    checkOutput("t6_idle_alu_a_held", alu_a, 32'hFFFF_FFFF);

    step();
    @(negedge clk);
    checkOutput("sb_empty", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one ALU instance between two requesters:
  - port 0: execute-stage integer ops;
  - port 1: address/branch-compare helper.
- Each request carries operands and a 4-bit ALU select code.
- The block grants round-robin, drives the shared ALU from registered operands, captures the result, and returns it to the owner over a valid/ready response channel.
- Sits between the requesters and the ALU. The ALU stays purely combinational outside this block.

## Interface

Parameters:
- `WIDTH`, 32: operand/result width.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `flush`, in, 1: synchronous abort of the in-flight operation.
- `req0_valid` / `req1_valid`, in, 1: request pending; must not depend combinationally on `reqN_ready`.
- `req0_ready` / `req1_ready`, out, 1: request accepted this cycle when high together with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`, in, WIDTH: operands.
- `req0_sel` / `req1_sel`, in, 4: ALU select code, passed through unmodified.
- `resp0_valid` / `resp1_valid`, out, 1: result available for that requester.
- `resp0_ready` / `resp1_ready`, in, 1: requester consumes the result.
- `resp_result`, out, WIDTH: result, shared by both response channels.
- `alu_a`, `alu_b`, out, WIDTH: operands to the shared ALU.
- `alu_sel`, out, 4: select code to the shared ALU.
- `alu_result`, in, WIDTH: combinational result from the ALU.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant:
    - only reqK valid: grant K;
    - both valid: grant the port that was NOT granted last (`last_grant` register).
  - `reqK_ready = (state==IDLE) & grant==K`. At most one ready is high at a time.
  - On handshake:
    - latch a, b, sel into `op_a`, `op_b`, `op_sel`;
    - set `owner=K` and `last_grant=K`;
    - go to EXEC.
- **EXEC** (exactly 1 cycle)
  - `alu_*` are driven from the latched registers.
  - At the clock edge, capture `alu_result` into `res_reg`, then go to RESP.
- **RESP**
  - `resp<owner>_valid=1`; the other resp_valid is 0.
  - `resp_result = res_reg`, held stable until the handshake.
  - When `resp<owner>_ready=1`, go to IDLE. The response is consumed and no new request is accepted in that cycle.
- **flush**
  - Sampled high in any state: next state IDLE, all resp_valid low next cycle, result discarded.
  - `last_grant` is updated only by accepted requests, so a flush does not change it.
  - A flush in IDLE blocks acceptance that cycle: both readies are forced 0.
- **ALU outputs**
  - `alu_a`, `alu_b`, `alu_sel` always reflect `op_a`, `op_b`, `op_sel`.
  - In IDLE they hold the last op. They are never driven from unregistered request inputs.
- Select codes are not interpreted. An undefined code yields whatever the ALU returns; the ALU default is 0.

## Timing

Reset values (`rst_n` low, asynchronous):
- state IDLE;
- `op_a`, `op_b`, `res_reg` = 0 and `op_sel` = 4'b0000;
- `owner` = 0;
- `last_grant` = 1, so port 0 wins the first contention;
- all resp_valid = 0 and `busy` = 0;
- readies follow IDLE rules once `rst_n` is released.

Latency and throughput:
- Request handshake at edge k.
- EXEC occupies the cycle after edge k.
- `res_reg` is loaded and resp_valid rises after edge k+1.
- With resp_ready held high, the response completes at edge k+2 and the state returns to IDLE.
- The next request can be accepted at edge k+3. Maximum throughput is 1 op / 3 cycles.

Backpressure and boundary cases:
- A response stalled in RESP holds `resp_result` and resp_valid indefinitely.
- The other requester sees ready=0 during the stall.
- A request whose valid drops before its handshake is not recorded.
- Reset asserted mid-EXEC or mid-RESP: outputs go to reset values immediately and no response is issued.

## Test plan

- **Single op, port 0**: req0 a=5, b=3, sel=0000 -> `req0_ready` at cycle 0; `resp0_valid` two cycles after the handshake; `resp_result`=8; `resp1_valid` stays 0.
- **Contention**: after reset, both valid every cycle with resp_ready=1.
  - req0 sel=1000, a=10, b=4; req1 sel=0100, a=0xF0, b=0x0F.
  - Expected: grants alternate 0, 1, 0, 1; results alternate 6, 0xFF; one op every 3 cycles.
- **Backpressure**: `resp1_ready` held low for 5 cycles after `resp1_valid`.
  - Expected: `resp_result` stable, state stays RESP, `req0_ready`=0 throughout.
  - Raising `resp1_ready` gives IDLE next cycle.
- **Flush**:
  - flush in EXEC -> no resp_valid ever asserted for that op; IDLE next cycle; `last_grant` unchanged.
  - flush in IDLE with req0 valid -> `req0_ready`=0 that cycle.
- **Async reset mid-RESP**: drop `rst_n` between edges -> resp_valid and `busy` fall immediately; after release, the first contention is won by port 0.
- **Signed pass-through**: sel=0010 (slt), a=0xFFFFFFFF, b=1 -> `alu_sel` and `alu_a` equal the latched values during EXEC; `resp_result`=1.
